// File: rtl/iter_divider_pkg.sv
// Shared types for the iterative divider: FSM states and the latched request record.
package iter_divider_pkg;

    // Widest WIDTH the request record can carry
    localparam int DIV_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

    typedef struct packed {
        logic [DIV_MAX_WIDTH-1:0] a;
        logic [DIV_MAX_WIDTH-1:0] b;
        logic                     is_signed;
        logic                     rem;
        logic                     word;
    } div_req_t;

endpackage

// File: rtl/iter_divider_if.sv
// Request/response handshake bundle between the execute stage and the divider.
interface iter_divider_if #(
    parameter int WIDTH = 64
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_signed;
    logic             in_rem;
    logic             in_word;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             busy;

    modport master (
        output flush, in_valid, in_a, in_b, in_signed, in_rem, in_word, out_ready,
        input  in_ready, out_valid, out_result, busy
    );

    modport slave (
        input  flush, in_valid, in_a, in_b, in_signed, in_rem, in_word, out_ready,
        output in_ready, out_valid, out_result, busy
    );
endinterface

// File: rtl/iter_divider_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, trial-subtract, keep if non-negative.
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // The top bit of diff is the borrow of the trial subtraction
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        diff    = shifted - {2'b00, divisor};
        if (!diff[WIDTH+1]) begin
            rem_out = diff[WIDTH:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = shifted[WIDTH:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/iter_divider.sv
// Iterative signed/unsigned DIV/REM unit, BITS_PER_CYCLE quotient bits per cycle.
// Define DIV_FASTPATH_EN to retire divide-by-zero and signed overflow straight from IDLE.
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          reset,
    iter_divider_if.slave dif
);
    localparam int N    = WIDTH / BITS_PER_CYCLE;
    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(N + 1);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    div_req_t         req_q, req_d;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q, dvs_q, result_q;
    logic [WIDTH:0]   rem_chain [BITS_PER_CYCLE+1];
    logic [WIDTH-1:0] quo_chain [BITS_PER_CYCLE+1];
    logic [WIDTH-1:0] a_ext, b_ext, a_mag, b_mag;
    logic [WIDTH-1:0] fixed_result, fast_result;
    logic             accept, fast_in;

    function automatic logic [WIDTH-1:0] finalize(input logic [WIDTH-1:0] v, input logic word);
        return word ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
    endfunction

    assign accept         = dif.in_valid && dif.in_ready && !dif.flush;
    assign dif.in_ready   = (state_q == IDLE);
    assign dif.out_valid  = (state_q == DONE);
    assign dif.busy       = (state_q != IDLE);
    assign dif.out_result = result_q;

    // Word ops see only the low half, extended so the full-width datapath produces the right answer
    always_comb begin
        a_ext = dif.in_a;
        b_ext = dif.in_b;
        if (dif.in_word) begin
            a_ext = {{HALF{dif.in_signed & dif.in_a[HALF-1]}}, dif.in_a[HALF-1:0]};
            b_ext = {{HALF{dif.in_signed & dif.in_b[HALF-1]}}, dif.in_b[HALF-1:0]};
        end
        a_mag           = (dif.in_signed && a_ext[WIDTH-1]) ? -a_ext : a_ext;
        b_mag           = (dif.in_signed && b_ext[WIDTH-1]) ? -b_ext : b_ext;
        req_d.a         = DIV_MAX_WIDTH'(a_ext);
        req_d.b         = DIV_MAX_WIDTH'(b_ext);
        req_d.is_signed = dif.in_signed;
        req_d.rem       = dif.in_rem;
        req_d.word      = dif.in_word;
    end

`ifdef DIV_FASTPATH_EN
    logic             dvz_in, ovf_in;
    logic [WIDTH-1:0] min_ext;

    // Results of the special cases are known at accept time
    always_comb begin
        min_ext     = dif.in_word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(WIDTH-1){1'b0}}};
        dvz_in      = (b_ext == '0);
        ovf_in      = dif.in_signed && (&b_ext) && (a_ext == min_ext);
        fast_in     = dvz_in || ovf_in;
        fast_result = finalize(dvz_in ? (dif.in_rem ? a_ext : '1) : (dif.in_rem ? '0 : a_ext), dif.in_word);
    end
`else
    assign fast_in     = 1'b0;
    assign fast_result = '0;
`endif

    assign rem_chain[0] = rem_q;
    assign quo_chain[0] = quo_q;
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .rem_in (rem_chain[i]),
            .quo_in (quo_chain[i]),
            .divisor(dvs_q),
            .rem_out(rem_chain[i+1]),
            .quo_out(quo_chain[i+1])
        );
    end

    // Sign fix-up on the final iteration's output; divide-by-zero quotient is forced to all ones
    always_comb begin
        logic             neg_a, neg_b, dvz;
        logic [WIDTH-1:0] quo_f, rem_f, q_s, r_s;
        neg_a        = req_q.is_signed & req_q.a[WIDTH-1];
        neg_b        = req_q.is_signed & req_q.b[WIDTH-1];
        dvz          = (req_q.b[WIDTH-1:0] == '0);
        quo_f        = quo_chain[BITS_PER_CYCLE];
        rem_f        = rem_chain[BITS_PER_CYCLE][WIDTH-1:0];
        q_s          = (neg_a ^ neg_b) ? -quo_f : quo_f;
        r_s          = neg_a ? -rem_f : rem_f;
        fixed_result = finalize(req_q.rem ? (dvz ? req_q.a[WIDTH-1:0] : r_s)
                                          : (dvz ? '1 : q_s), req_q.word);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = fast_in ? DONE : BUSY;
            BUSY:    if (cnt_q == CW'(N - 1)) state_d = DONE;
            DONE:    if (dif.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (dif.flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Datapath registers; result_q only holds a value while in DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            req_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else if (dif.flush) begin
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    req_q <= req_d;
                    rem_q <= '0;
                    quo_q <= a_mag;
                    dvs_q <= b_mag;
                    cnt_q <= '0;
                    if (fast_in) result_q <= fast_result;
                end
                BUSY: begin
                    rem_q <= rem_chain[BITS_PER_CYCLE];
                    quo_q <= quo_chain[BITS_PER_CYCLE];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) result_q <= fixed_result;
                end
                DONE: if (dif.out_ready) result_q <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider at BITS_PER_CYCLE = 1, 2 and 4 (64-bit width).
module tb_iter_divider;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
    localparam int          NV   = 22;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sgn;
        logic        rem;
        logic        word;
        logic [63:0] exp;
        int          hold;
    } vec_t;

    logic        clk, reset, flush, in_valid, out_ready;
    logic [63:0] in_a, in_b;
    logic        in_signed, in_rem, in_word;
    logic        obs_in_ready, obs_out_valid, obs_busy;
    logic [63:0] obs_out_result;
    int          sel;
    int          checks, failures;
    vec_t        tbl [NV];
    logic [63:0] exp_q [$];
    int          lat_q [$];

    iter_divider_if #(.WIDTH(64)) if1 ();
    iter_divider_if #(.WIDTH(64)) if2 ();
    iter_divider_if #(.WIDTH(64)) if4 ();

    iter_divider #(.WIDTH(64), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .reset(reset), .dif(if1));
    iter_divider #(.WIDTH(64), .BITS_PER_CYCLE(2)) dut2 (.clk(clk), .reset(reset), .dif(if2));
    iter_divider #(.WIDTH(64), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .reset(reset), .dif(if4));

    // Shared operand bus; only the selected divider sees in_valid/out_ready
    assign if1.flush = flush;  assign if2.flush = flush;  assign if4.flush = flush;
    assign if1.in_a = in_a;    assign if2.in_a = in_a;    assign if4.in_a = in_a;
    assign if1.in_b = in_b;    assign if2.in_b = in_b;    assign if4.in_b = in_b;
    assign if1.in_signed = in_signed; assign if2.in_signed = in_signed; assign if4.in_signed = in_signed;
    assign if1.in_rem = in_rem;       assign if2.in_rem = in_rem;       assign if4.in_rem = in_rem;
    assign if1.in_word = in_word;     assign if2.in_word = in_word;     assign if4.in_word = in_word;
    assign if1.in_valid  = in_valid  && (sel == 0);
    assign if2.in_valid  = in_valid  && (sel == 1);
    assign if4.in_valid  = in_valid  && (sel == 2);
    assign if1.out_ready = out_ready && (sel == 0);
    assign if2.out_ready = out_ready && (sel == 1);
    assign if4.out_ready = out_ready && (sel == 2);

    always_comb begin
        obs_in_ready   = if1.in_ready;
        obs_out_valid  = if1.out_valid;
        obs_out_result = if1.out_result;
        obs_busy       = if1.busy;
        if (sel == 1) begin
            obs_in_ready   = if2.in_ready;
            obs_out_valid  = if2.out_valid;
            obs_out_result = if2.out_result;
            obs_busy       = if2.busy;
        end else if (sel == 2) begin
            obs_in_ready   = if4.in_ready;
            obs_out_valid  = if4.out_valid;
            obs_out_result = if4.out_result;
            obs_busy       = if4.busy;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic sgn, input logic rem, input logic word);
        logic [31:0] a32, b32, r32;
        logic [63:0] r;
        if (word) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0)                                          r32 = rem ? a32 : 32'hFFFF_FFFF;
            else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = rem ? 32'd0 : 32'h8000_0000;
            else if (sgn) r32 = rem ? $signed(a32) % $signed(b32) : $signed(a32) / $signed(b32);
            else          r32 = rem ? a32 % b32 : a32 / b32;
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0)                          r = rem ? a : ONES;
            else if (sgn && a == MIN && b == ONES)   r = rem ? 64'd0 : MIN;
            else if (sgn) r = rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
            else          r = rem ? a % b : a / b;
        end
        return r;
    endfunction

    function automatic bit isSpecial(input logic [63:0] a, input logic [63:0] b, input logic sgn, input logic word);
        if (word) return (b[31:0] == 32'd0) || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'd0) || (sgn && a == MIN && b == ONES);
    endfunction

    function automatic int expLat(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                                  input logic word, input int n);
`ifdef DIV_FASTPATH_EN
        if (isSpecial(a, b, sgn, word)) return 1;
`endif
        return n + 1;
    endfunction

    task automatic checkValue(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic loadTable();
        tbl[0]  = '{64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, 0};
        tbl[1]  = '{64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 64'd2, 0};
        tbl[2]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 0};
        tbl[3]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b0, ONES, 0};
        tbl[4]  = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 0};
        tbl[5]  = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 1'b0, 64'd1, 0};
        tbl[6]  = '{64'h1234, 64'd0, 1'b0, 1'b0, 1'b0, ONES, 0};
        tbl[7]  = '{64'h1234, 64'd0, 1'b0, 1'b1, 1'b0, 64'h1234, 0};
        tbl[8]  = '{64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 0};
        tbl[9]  = '{MIN, ONES, 1'b1, 1'b0, 1'b0, MIN, 0};
        tbl[10] = '{MIN, ONES, 1'b1, 1'b1, 1'b0, 64'd0, 0};
        tbl[11] = '{64'h8000_0000, ONES, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 0};
        tbl[12] = '{64'h8000_0000, ONES, 1'b1, 1'b1, 1'b1, 64'd0, 0};
        tbl[13] = '{64'hFFFF_FFFF_0000_0010, 64'd3, 1'b0, 1'b0, 1'b1, 64'd5, 10};
        tbl[14] = '{64'hFFFF_FFFF_0000_0010, 64'd3, 1'b0, 1'b1, 1'b1, 64'd1, 0};
        tbl[15] = '{ONES, 64'd2, 1'b0, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 0};
        tbl[16] = '{64'd5, 64'd10, 1'b0, 1'b1, 1'b0, 64'd5, 0};
        tbl[17] = '{64'h1234_5678_FFFF_FF9C, 64'd7, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 0};
        tbl[18] = '{64'h1234_5678_FFFF_FF9C, 64'd7, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 0};
        tbl[19] = '{64'h8000_0000, 64'd0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 0};
        tbl[20] = '{64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, 1'b0, 1'b0, ONES, 0};
        tbl[21] = '{64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1, ONES, 0};
    endtask

    task automatic startOp(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                           input logic rem, input logic word, output bit ok);
        int guard;
        @(negedge clk);
        in_a = a; in_b = b; in_signed = sgn; in_rem = rem; in_word = word; in_valid = 1'b1;
        guard = 0;
        while (!obs_in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!obs_in_ready) begin
            failures++;
            $display("[TB] FAIL accept_timeout in_ready=0 required=1");
            in_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        ok = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                                 input logic rem, input logic word, input logic [63:0] exp, input int lat);
        bit ok;
        exp_q.push_back(exp);
        lat_q.push_back(lat);
        startOp(a, b, sgn, rem, word, ok);
        if (!ok) begin
            void'(exp_q.pop_back());
            void'(lat_q.pop_back());
        end
    endtask

    task automatic checkOutput(input string name, input int hold);
        logic [63:0] exp;
        int          exp_lat, lat;
        if (exp_q.size() == 0) return;
        exp     = exp_q.pop_front();
        exp_lat = lat_q.pop_front();
        lat     = 1;
        @(negedge clk);
        while (!obs_out_valid && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checkValue({name, "_latency"}, 64'(lat), 64'(exp_lat));
        if (!obs_out_valid) return;
        checkValue({name, "_result"}, obs_out_result, exp);
        checkValue({name, "_in_ready_done"}, {63'd0, obs_in_ready}, 64'd0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            checkValue({name, "_held_result"}, obs_out_result, exp);
            checkValue({name, "_held_valid"}, {63'd0, obs_out_valid}, 64'd1);
            checkValue({name, "_held_in_ready"}, {63'd0, obs_in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checkValue({name, "_valid_after_take"}, {63'd0, obs_out_valid}, 64'd0);
        checkValue({name, "_result_after_take"}, obs_out_result, 64'd0);
        checkValue({name, "_busy_after_take"}, {63'd0, obs_busy}, 64'd0);
    endtask

    task automatic flushSequence(input int n);
        bit ok;
        startOp(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, ok);
        if (!ok) return;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkValue("flush_busy_before", {63'd0, obs_busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checkValue("flush_out_valid", {63'd0, obs_out_valid}, 64'd0);
        checkValue("flush_in_ready", {63'd0, obs_in_ready}, 64'd1);
        checkValue("flush_busy", {63'd0, obs_busy}, 64'd0);
        checkValue("flush_result", obs_out_result, 64'd0);
        applyStimulus(64'd1000, 64'd9, 1'b0, 1'b0, 1'b0, 64'd111, n + 1);
        checkOutput($sformatf("after_flush_n%0d", n), 0);
    endtask

    initial begin
        logic [63:0] ra, rb;
        logic        rs, rr, rw;
        int          n;
        bit          ok;
        checks = 0; failures = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_signed = 1'b0; in_rem = 1'b0; in_word = 1'b0;
        sel = 0;
        loadTable();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checkValue("reset_in_ready", {63'd0, obs_in_ready}, 64'd1);
            checkValue("reset_out_valid", {63'd0, obs_out_valid}, 64'd0);
            checkValue("reset_busy", {63'd0, obs_busy}, 64'd0);
            checkValue("reset_result", obs_out_result, 64'd0);
        end
        sel = 0;
        reset = 1'b0;

        // Flush wins over a simultaneous request in IDLE
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        checkValue("flush_beats_accept", {63'd0, obs_busy}, 64'd0);

        for (int s = 0; s < 3; s++) begin
            sel = s;
            n   = 64 >> s;
            for (int i = 0; i < NV; i++) begin
                applyStimulus(tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].rem, tbl[i].word, tbl[i].exp,
                              expLat(tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].word, n));
                checkOutput($sformatf("vec%0d_n%0d", i, n), (s == 0) ? tbl[i].hold : 0);
            end
            for (int i = 0; i < 6; i++) begin
                ra = {$urandom, $urandom};
                case ($urandom_range(0, 3))
                    0:       rb = {32'd0, $urandom};
                    1:       rb = 64'($urandom_range(1, 15));
                    2:       rb = {$urandom, $urandom};
                    default: rb = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                endcase
                rs = 1'($urandom_range(0, 1));
                rr = 1'($urandom_range(0, 1));
                rw = 1'($urandom_range(0, 1));
                applyStimulus(ra, rb, rs, rr, rw, model(ra, rb, rs, rr, rw), expLat(ra, rb, rs, rw, n));
                checkOutput($sformatf("rand%0d_n%0d", i, n), 0);
            end
            flushSequence(n);
        end

        // Reset in the middle of an operation leaves nothing behind
        sel = 0;
        startOp(64'd12345, 64'd11, 1'b0, 1'b0, 1'b0, ok);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkValue("midreset_busy", {63'd0, obs_busy}, 64'd0);
        checkValue("midreset_out_valid", {63'd0, obs_out_valid}, 64'd0);
        checkValue("midreset_in_ready", {63'd0, obs_in_ready}, 64'd1);
        checkValue("midreset_result", obs_out_result, 64'd0);
        reset = 1'b0;
        applyStimulus(64'd12345, 64'd11, 1'b0, 1'b1, 1'b0, 64'd3, 65);
        checkOutput("after_midreset", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
